writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 147 ++++++++++++++
 tb/tb_writeback_stage.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU results directly and loads after a memory
// handshake, driving one-cycle strobes into the general or label register file.
module writeback_stage #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_rd,
  input  logic [7:0] in_data,
  input  logic [7:0] in_addr,
  input  logic       in_is_load,
  input  logic       in_is_label,
  input  logic       in_wb_en,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic [2:0] rd,
  output logic [7:0] write_data,
  output logic       reg_write,
  output logic       label_write,
  output logic       bad_rd,
  output logic       mem_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    WRITE    = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_r;
  logic [7:0] cnt_r;
  logic [2:0] pend_rd_r;
  logic       pend_label_r;
  logic       pend_wb_r;

  logic       accept_s;
  logic       wr_go_s;
  logic       wr_wb_s;
  logic       wr_label_s;
  logic [2:0] wr_rd_s;
  logic [7:0] wr_data_s;

  // Indices 6 and 7 are not backed by storage in either register file.
  function automatic logic rd_is_bad(input logic [2:0] idx);
    return idx[2] & idx[1];
  endfunction

  assign in_ready = rst_n && (state_r != MEM_WAIT);
  assign accept_s = in_valid && in_ready;

  // Select the retiring op: a completed load in MEM_WAIT, otherwise an accepted ALU op.
  always_comb begin
    wr_go_s    = 1'b0;
    wr_wb_s    = 1'b0;
    wr_label_s = 1'b0;
    wr_rd_s    = 3'd0;
    wr_data_s  = 8'd0;
    if (state_r == MEM_WAIT) begin
      wr_go_s    = mem_ack;
      wr_wb_s    = pend_wb_r;
      wr_label_s = pend_label_r;
      wr_rd_s    = pend_rd_r;
      wr_data_s  = mem_rdata;
    end else begin
      wr_go_s    = accept_s && !in_is_load;
      wr_wb_s    = in_wb_en;
      wr_label_s = in_is_label;
      wr_rd_s    = in_rd;
      wr_data_s  = in_data;
    end
  end

  // Stage FSM, memory handshake, timeout counter and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 8'd0;
      pend_rd_r    <= 3'd0;
      pend_label_r <= 1'b0;
      pend_wb_r    <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= 8'd0;
      rd           <= 3'd0;
      write_data   <= 8'd0;
      reg_write    <= 1'b0;
      label_write  <= 1'b0;
      bad_rd       <= 1'b0;
      mem_err      <= 1'b0;
    end else begin
      reg_write   <= 1'b0;
      label_write <= 1'b0;

      if (wr_go_s && wr_wb_s) begin
        if (rd_is_bad(wr_rd_s)) begin
          bad_rd <= 1'b1;
        end else begin
          rd          <= wr_rd_s;
          write_data  <= wr_data_s;
          reg_write   <= !wr_label_s;
          label_write <= wr_label_s;
        end
      end

      case (state_r)
        IDLE, WRITE: begin
          if (accept_s && in_is_load) begin
            state_r      <= MEM_WAIT;
            mem_req      <= 1'b1;
            mem_addr     <= in_addr;
            cnt_r        <= 8'd0;
            pend_rd_r    <= in_rd;
            pend_label_r <= in_is_label;
            pend_wb_r    <= in_wb_en;
          end else if (accept_s) begin
            state_r <= WRITE;
          end else begin
            state_r <= IDLE;
          end
        end
        MEM_WAIT: begin
          // An ack in the final wait cycle takes priority over the timeout.
          if (mem_ack) begin
            mem_req <= 1'b0;
            state_r <= WRITE;
          end else if (cnt_r == TIMEOUT_LAST) begin
            mem_req <= 1'b0;
            mem_err <= 1'b1;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus a randomized
// op stream scored against a transaction-level model of the retire rules.
module tb_writeback_stage;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_rd;
  logic [7:0] in_data;
  logic [7:0] in_addr;
  logic       in_is_load;
  logic       in_is_label;
  logic       in_wb_en;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [2:0] rd;
  logic [7:0] write_data;
  logic       reg_write;
  logic       label_write;
  logic       bad_rd;
  logic       mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  // model of the visible register-file port
  logic [2:0] last_rd;
  logic [7:0] last_data;
  logic       exp_bad;
  logic       exp_err;

  writeback_stage #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data), .in_addr(in_addr),
    .in_is_load(in_is_load), .in_is_label(in_is_label), .in_wb_en(in_wb_en),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rd(rd), .write_data(write_data), .reg_write(reg_write), .label_write(label_write),
    .bad_rd(bad_rd), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] r, input logic [7:0] d,
                       input logic [7:0] a, input logic ld, input logic lb, input logic wb);
    in_valid = v; in_rd = r; in_data = d; in_addr = a;
    in_is_load = ld; in_is_label = lb; in_wb_en = wb;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    mem_ack = 1'b0; mem_rdata = 8'd0;
    repeat (3) tick();
    n_cmp++;
    if ({in_ready, mem_req, mem_addr, rd, write_data, reg_write, label_write, bad_rd, mem_err} !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {in_ready, mem_req, mem_addr, rd, write_data, reg_write, label_write, bad_rd, mem_err});
    end
    rst_n = 1'b1;
  endtask

  // Also covers acceptance in the very first cycle after reset release.
  task automatic test_alu_write();
    drive(1'b1, 3'd2, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if ({reg_write, label_write, rd, write_data} !== {1'b1, 1'b0, 3'd2, 8'h5A}) begin
      n_bad++;
      $display("FAIL alu_write: got %h want %h", {reg_write, label_write, rd, write_data},
               {1'b1, 1'b0, 3'd2, 8'h5A});
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if ({reg_write, label_write, rd, write_data} !== {1'b0, 1'b0, 3'd2, 8'h5A}) begin
      n_bad++;
      $display("FAIL alu_single_pulse: got %h want %h", {reg_write, label_write, rd, write_data},
               {1'b0, 1'b0, 3'd2, 8'h5A});
    end
  endtask

  task automatic test_load_ack();
    int errs = 0;
    drive(1'b1, 3'd1, 8'h00, 8'h10, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 3'd3, 8'hFF, 8'hAA, 1'b0, 1'b0, 1'b1); // ignored while waiting
    for (int k = 1; k <= 3; k++) begin
      if (!(mem_req === 1'b1 && mem_addr === 8'h10 && in_ready === 1'b0 &&
            reg_write === 1'b0 && label_write === 1'b0)) errs++;
      mem_ack = (k == 3); mem_rdata = (k == 3) ? 8'hC3 : 8'h99;
      tick();
    end
    mem_ack = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (errs != 0) begin
      n_bad++;
      $display("FAIL load_wait: got %0d bad wait cycles want 0", errs);
    end
    n_cmp++;
    if ({label_write, reg_write, rd, write_data, mem_req} !== {1'b1, 1'b0, 3'd1, 8'hC3, 1'b0}) begin
      n_bad++;
      $display("FAIL load_write: got %h want %h", {label_write, reg_write, rd, write_data, mem_req},
               {1'b1, 1'b0, 3'd1, 8'hC3, 1'b0});
    end
    tick();
    n_cmp++;
    if ({label_write, reg_write} !== 2'b00) begin
      n_bad++;
      $display("FAIL load_single_pulse: got %b want 00", {label_write, reg_write});
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] rds [3] = '{3'd0, 3'd3, 3'd5};
    logic [7:0] vals [3] = '{8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rds[i], vals[i], 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      n_cmp++;
      if ({reg_write, rd, write_data} !== {1'b1, rds[i], vals[i]}) begin
        n_bad++;
        $display("FAIL b2b_%0d: got %h want %h", i, {reg_write, rd, write_data}, {1'b1, rds[i], vals[i]});
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (reg_write !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_end: got %b want 0", reg_write);
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int strobes = 0;
    drive(1'b1, 3'd3, 8'h00, 8'h33, 1'b1, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < TO + 2; k++) begin
      if (mem_req === 1'b1) req_cycles++;
      if (reg_write === 1'b1 || label_write === 1'b1) strobes++;
      tick();
    end
    n_cmp++;
    if (req_cycles != TO || strobes != 0) begin
      n_bad++;
      $display("FAIL timeout_req: got req=%0d strobes=%0d want req=%0d strobes=0", req_cycles, strobes, TO);
    end
    n_cmp++;
    if ({mem_err, in_ready} !== 2'b11) begin
      n_bad++;
      $display("FAIL timeout_err: got %b want 11", {mem_err, in_ready});
    end
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    tick();
    mem_ack = 1'b0;
    tick();
    n_cmp++;
    if ({reg_write, label_write, write_data} !== {1'b0, 1'b0, 8'h03}) begin
      n_bad++;
      $display("FAIL late_ack: got %h want %h", {reg_write, label_write, write_data}, {1'b0, 1'b0, 8'h03});
    end
  endtask

  task automatic test_bad_rd();
    drive(1'b1, 3'd4, 8'h44, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if ({reg_write, label_write, bad_rd, rd, write_data} !== {1'b0, 1'b0, 1'b0, 3'd5, 8'h03}) begin
      n_bad++;
      $display("FAIL wb_off: got %h want %h", {reg_write, label_write, bad_rd, rd, write_data},
               {1'b0, 1'b0, 1'b0, 3'd5, 8'h03});
    end
    drive(1'b1, 3'd7, 8'h77, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({reg_write, label_write, bad_rd, rd, write_data} !== {1'b0, 1'b0, 1'b1, 3'd5, 8'h03}) begin
      n_bad++;
      $display("FAIL bad_rd7: got %h want %h", {reg_write, label_write, bad_rd, rd, write_data},
               {1'b0, 1'b0, 1'b1, 3'd5, 8'h03});
    end
    tick();
  endtask

  task automatic test_reset_mid_load();
    drive(1'b1, 3'd2, 8'h00, 8'h80, 1'b1, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL midload_req: got %b want 1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, mem_req, mem_addr, rd, write_data, reg_write, label_write, bad_rd, mem_err} !== 25'd0) begin
      n_bad++;
      $display("FAIL midload_reset: got %h want 0",
               {in_ready, mem_req, mem_addr, rd, write_data, reg_write, label_write, bad_rd, mem_err});
    end
    tick();
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 8'h5F;
    tick();
    mem_ack = 1'b0;
    n_cmp++;
    if ({reg_write, label_write, mem_req, write_data} !== 11'd0) begin
      n_bad++;
      $display("FAIL midload_nowrite: got %h want 0", {reg_write, label_write, mem_req, write_data});
    end
    drive(1'b1, 3'd5, 8'h77, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({reg_write, rd, write_data} !== {1'b1, 3'd5, 8'h77}) begin
      n_bad++;
      $display("FAIL midload_accept: got %h want %h", {reg_write, rd, write_data}, {1'b1, 3'd5, 8'h77});
    end
    last_rd = 3'd5; last_data = 8'h77; exp_bad = 1'b0; exp_err = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic [2:0] r    = 3'($urandom_range(0, 7));
      logic [7:0] d    = 8'($urandom);
      logic [7:0] a    = 8'($urandom);
      logic [7:0] md   = 8'($urandom);
      logic       ld   = ($urandom_range(0, 2) == 0);
      logic       lb   = 1'($urandom);
      logic       wb   = ($urandom_range(0, 4) != 0);
      int         dly  = $urandom_range(1, TO + 3);
      logic       timed = 1'b0;
      logic [7:0] val;
      logic       do_write;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL rnd_ready_%0d: got %b want 1", n, in_ready);
      end
      drive(1'b1, r, d, a, ld, lb, wb);
      tick();
      val = d;
      if (ld) begin
        int werr = 0;
        timed = 1'b1;
        drive(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        for (int k = 1; k <= TO; k++) begin
          if (!(mem_req === 1'b1 && mem_addr === a && in_ready === 1'b0 &&
                reg_write === 1'b0 && label_write === 1'b0)) werr++;
          mem_ack = (k == dly); mem_rdata = (k == dly) ? md : 8'($urandom);
          tick();
          if (k == dly) begin
            timed = 1'b0;
            break;
          end
        end
        mem_ack = 1'b0; in_valid = 1'b0;
        val = md;
        n_cmp++;
        if (werr != 0 || mem_req !== 1'b0) begin
          n_bad++;
          $display("FAIL rnd_wait_%0d: got bad=%0d req=%b want bad=0 req=0", n, werr, mem_req);
        end
      end
      if (timed) exp_err = 1'b1;
      do_write = !timed && wb && (r < 3'd6);
      if (!timed && wb && r >= 3'd6) exp_bad = 1'b1;
      if (do_write) begin
        last_rd = r; last_data = val;
      end
      n_cmp++;
      if ({reg_write, label_write, rd, write_data, bad_rd, mem_err} !==
          {do_write && !lb, do_write && lb, last_rd, last_data, exp_bad, exp_err}) begin
        n_bad++;
        $display("FAIL rnd_op_%0d: got %h want %h", n,
                 {reg_write, label_write, rd, write_data, bad_rd, mem_err},
                 {do_write && !lb, do_write && lb, last_rd, last_data, exp_bad, exp_err});
      end
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        mem_ack = 1'($urandom); mem_rdata = 8'($urandom);
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if ({reg_write, label_write, rd, write_data} !== {1'b0, 1'b0, last_rd, last_data}) begin
          n_bad++;
          $display("FAIL rnd_idle_%0d: got %h want %h", n, {reg_write, label_write, rd, write_data},
                   {1'b0, 1'b0, last_rd, last_data});
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alu_write();
    test_load_ack();
    test_back_to_back();
    test_timeout();
    test_bad_rd();
    test_reset_mid_load();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
